matrix_operand_loader: RTL

- Upstream stage of the 2x2 8-bit matrix multiplier.
- Accepts a byte stream over a valid/ready handshake and assembles one 8-byte frame into two packed 32-bit operands: A (bytes 0-3), then B (bytes 4-7).
- Presents A/B to the multiplier with an out_valid/out_ready handshake.
- Checks frame alignment using in_last, and resynchronises after framing errors.

---
 rtl/matrix_operand_loader.sv | 88 ++++++++
 1 files changed

// File: rtl/matrix_operand_loader.sv
// Packs an 8-byte frame into A/B operands; out_valid rises 1 cycle after the last byte.
// in_ready is low while a pair is presented, and rises again the cycle after out_valid&&out_ready.
module matrix_operand_loader #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic [CNT_W-1:0] pair_count
);

    typedef enum logic [1:0] {LOAD, PRESENT, DRAIN} state_t;

    state_t     state;
    logic [2:0] idx;
    logic       in_acc;
    logic       out_acc;
    logic       at_end;
    logic       lane_ok;
    logic [1:0] lane;

    assign in_ready = (state != PRESENT);
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign at_end   = (idx == 3'd7);
    // A byte is kept only when in_last agrees with its position in the frame
    assign lane_ok  = (at_end == in_last);
    // MSB-first lanes: idx 0 lands in bits [31:24]
    assign lane     = ~idx[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            idx        <= 3'd0;
            A          <= 32'd0;
            B          <= 32'd0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            pair_count <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_acc) begin
                        idx <= in_last ? 3'd0 : idx + 3'd1;
                        if (lane_ok) begin
                            if (!idx[2])
                                A[{lane, 3'b000} +: 8] <= in_data;
                            else
                                B[{lane, 3'b000} +: 8] <= in_data;
                        end
                        if (at_end && in_last) begin
                            state     <= PRESENT;
                            out_valid <= 1'b1;
                        end else if (!lane_ok) begin
                            frame_err <= 1'b1;
                            if (at_end)
                                state <= DRAIN;
                        end
                    end
                end
                PRESENT: begin
                    if (out_acc) begin
                        out_valid  <= 1'b0;
                        state      <= LOAD;
                        pair_count <= pair_count + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (in_acc && in_last) begin
                        state <= LOAD;
                        idx   <= 3'd0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
